flex_updown_counter: RTL
========================

Name: flex_updown_counter

Overview:
Parametrised up/down counter for the calculator datapath and control timing. It adds direction control, a wrap or saturate mode, synchronous load, and separate terminal flags to the team's basic rollover counter. It is used for operand/digit indexing and for multi-cycle operation sequencing.
The count range is 1..rollover_val. The value 0 exists only after reset or clear, or when loaded explicitly.

Parameters:
SIZE, 4, width of the count, load and rollover values (≥2)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
clear  input  1  synchronous clear to 0; highest priority
load  input  1  synchronous load of load_val
load_val  input  SIZE  value loaded when load=1
count_enable  input  1  advance one step per cycle while high
dir  input  1  0 = up, 1 = down (dir_t)
mode  input  1  0 = wrap, 1 = saturate (mode_t)
rollover_val  input  SIZE  upper terminal value; sampled every cycle
count_out  output  SIZE  current count (registered)
max_flag  output  1  registered; high while count_out == rollover_val
min_flag  output  1  registered; high while count_out == 1
wrap_pulse  output  1  registered; one-cycle high in the cycle count_out first shows a wrapped value

Behaviour:
- Reset: rst=1 forces count_out=0, max_flag=0, min_flag=0, wrap_pulse=0 immediately, asynchronously, independent of clk. Reset mid-count discards state. The first edge after deassertion evaluates normally from 0.
- Priority per cycle: clear > load > count_enable > hold.
- clear: next_count=0 and no wrap event.
- load: next_count=load_val verbatim, with no range clamp and no wrap event. Out-of-range values are legal. The next count applies the rules below.
- Up count (dir=0):
  - If count_out ≥ rollover_val: wrap mode gives next=1 and a wrap event; saturate mode gives next=rollover_val and no event.
  - Otherwise next=count_out+1.
- Down count (dir=1):
  - If count_out ≤ 1: wrap mode gives next=rollover_val and a wrap event; saturate mode gives next=1 and no event (0 saturates to 1).
  - Otherwise next=count_out−1.
- Arithmetic is SIZE-bit unsigned. The comparisons above guarantee the count never overflows or underflows through 0.
- Flags:
  - max_flag <= (next_count == rollover_val).
  - min_flag <= (next_count == 1).
  - Flags are updated every cycle, including hold, clear and load cycles, so a rollover_val change shows on max_flag one cycle later.
- wrap_pulse <= wrap event this cycle. It is never high two consecutive cycles unless wraps occur on consecutive enabled cycles, e.g. rollover_val=1 up.
- Degenerate rollover_val=0:
  - Up, wrap mode: each enabled cycle yields 1 with a wrap event.
  - Down, wrap mode: yields 0 with a wrap event.
  - Saturate mode: holds at 0 (up) or 1 (down).
  - This is documented behaviour, not an error.
- dir and mode changes take effect on the same edge they are sampled. No pipeline; latency from control input to count_out is 1 cycle.

Decomposition:
- Shared package counter_pkg:
  - typedef enum logic {DIR_UP=1'b0, DIR_DOWN=1'b1} dir_t
  - typedef enum logic {MODE_WRAP=1'b0, MODE_SAT=1'b1} mode_t
  - localparam MIN_COUNT = 1
- No sub-module. One always_ff holds the state registers (count, two flags, wrap_pulse); one always_comb computes next_count, next flags and the wrap event.

Test Plan:
- Reset: SIZE=4, count at 3, assert rst between edges → count_out=0 and all flags 0 before the next edge. Deassert, enable up, rv=5 → count 1 after the first edge.
- Up wrap: rv=5, mode=wrap, enable 6 cycles from 0 → count 1,2,3,4,5,1. max_flag=1 with count 5. On the last edge count=1, wrap_pulse=1 and min_flag=1, then wrap_pulse drops the next cycle.
- Down wrap: load 2, then dir=1, rv=5, enable 3 cycles → count 1,5,4. wrap_pulse=1 only with the 5; min_flag=1 with 1; max_flag=1 with 5.
- Saturate: rv=3, mode=sat, up from 0 for 5 cycles → count 1,2,3,3,3. max_flag stays 1 and wrap_pulse never rises. Switch dir=1 for 4 cycles → 2,1,1,1.
- Priority/out-of-range:
  - clear=load=count_enable=1 with load_val=7 → count 0.
  - Next cycle load=1, load_val=9, rv=5 → count 9.
  - Then up enable, wrap mode → count 1, wrap_pulse=1.
- Live rollover change: hold at count 4 (enable=0), rv changes 5→4 → count stays 4, max_flag rises exactly one cycle later.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and constants for the flexible up/down counter family.
package counter_pkg;

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;
  typedef enum logic {MODE_WRAP = 1'b0, MODE_SAT = 1'b1} mode_t;

  localparam int MIN_COUNT = 1;

endpackage

// File: rtl/flex_updown_counter.sv
// Up/down counter over 1..rollover_val with wrap/saturate modes, synchronous
// clear/load and registered terminal flags plus a one-cycle wrap pulse.
module flex_updown_counter
  import counter_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            load,
  input  logic [SIZE-1:0] load_val,
  input  logic            count_enable,
  input  logic            dir,
  input  logic            mode,
  input  logic [SIZE-1:0] rollover_val,
  output logic [SIZE-1:0] count_out,
  output logic            max_flag,
  output logic            min_flag,
  output logic            wrap_pulse
);

  localparam logic [SIZE-1:0] MIN_V = SIZE'(MIN_COUNT);
  localparam logic [SIZE-1:0] ONE   = SIZE'(1);

  dir_t  dir_s;
  mode_t mode_s;

  logic [SIZE-1:0] count_q, count_d;
  logic            max_q, max_d;
  logic            min_q, min_d;
  logic            wrap_q, wrap_d;

  assign dir_s  = dir_t'(dir);
  assign mode_s = mode_t'(mode);

  // The range checks use >= / <= so out-of-range loaded values (including 0)
  // are pulled back into 1..rollover_val instead of running through 0.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (count_enable) begin
      if (dir_s == DIR_UP) begin
        if (count_q >= rollover_val) begin
          if (mode_s == MODE_WRAP) begin
            count_d = MIN_V;
            wrap_d  = 1'b1;
          end else begin
            count_d = rollover_val;
          end
        end else begin
          count_d = count_q + ONE;
        end
      end else begin
        if (count_q <= MIN_V) begin
          if (mode_s == MODE_WRAP) begin
            count_d = rollover_val;
            wrap_d  = 1'b1;
          end else begin
            count_d = MIN_V;
          end
        end else begin
          count_d = count_q - ONE;
        end
      end
    end
    max_d = (count_d == rollover_val);
    min_d = (count_d == MIN_V);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      max_q   <= 1'b0;
      min_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      max_q   <= max_d;
      min_q   <= min_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count_out  = count_q;
  assign max_flag   = max_q;
  assign min_flag   = min_q;
  assign wrap_pulse = wrap_q;

endmodule
